// File: rtl/stream_demux.sv
// Registered 1-to-4 stream demultiplexer with per-channel one-entry output registers.
// Optional per-channel accepted-beat counters enabled by defining STREAM_DEMUX_CNT_EN.
module stream_demux #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [4*CNT_W-1:0] cnt,
  input  logic               cnt_clr
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("stream_demux: WIDTH and CNT_W must be at least 1");
  end

  logic [3:0]            vld_q, vld_d;
  logic [3:0][WIDTH-1:0] dat_q, dat_d;
  logic                  in_xfer;

  // Only the addressed channel can stall the input, so a full channel never blocks others.
  assign in_ready = ~vld_q[in_sel] | out_ready[in_sel];
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (vld_q[k] && out_ready[k]) begin
        vld_d[k] = 1'b0;
      end
      if (in_xfer && in_sel == 2'(k)) begin
        vld_d[k] = 1'b1;
        dat_d[k] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = dat_q;

`ifdef STREAM_DEMUX_CNT_EN
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (cnt_clr) begin
        cnt_d[k] = '0;
      end else if (in_xfer && in_sel == 2'(k)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-4 stream demultiplexer. It is the receiving end of the 4:1 `encoder` selector path: it takes one WIDTH-bit stream tagged with a 2-bit destination select and steers each beat to one of four output channels `a`–`d`. Each channel has its own one-entry output register and a valid/ready handshake. A stalled channel blocks only beats addressed to it.

## Interface
Parameters:
- `WIDTH`, default 4: data width per beat.
- `CNT_W`, default 8: width of each per-channel beat counter (used only when `STREAM_DEMUX_CNT_EN` is defined).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input WIDTH: beat payload.
- `in_sel` input 2: destination channel; 0=a, 1=b, 2=c, 3=d.
- `in_valid` input 1: `in_data` and `in_sel` are valid.
- `in_ready` output 1: beat is accepted this cycle if `in_valid` is high.
- `out_data` output 4*WIDTH: channel k payload at bits [k*WIDTH +: WIDTH].
- `out_valid` output 4: channel k holds a beat.
- `out_ready` input 4: the channel k sink accepts its beat this cycle.
- `cnt` output 4*CNT_W: present only with `STREAM_DEMUX_CNT_EN`; channel k counter at bits [k*CNT_W +: CNT_W].
- `cnt_clr` input 1: present only with `STREAM_DEMUX_CNT_EN`; synchronous clear of all counters.

## Operation
- Per channel k, state is `vld[k]` and `dat[k]`, driven directly onto `out_valid[k]` and `out_data` slice k.
- `in_ready = ~vld[in_sel] | out_ready[in_sel]`. This is combinational from `in_sel` and `out_ready`, with no dependence on `in_valid`.
- Input transfer: `in_valid & in_ready`. On a transfer, channel `in_sel` loads `dat <= in_data` and sets `vld <= 1`.
- Output transfer on channel k: `vld[k] & out_ready[k]`. If channel k is not loaded in the same cycle, `vld[k] <= 0`.
- Simultaneous drain and load on the same channel: the new data replaces the old and `vld` stays 1. This gives full throughput of one beat per cycle per channel.
- Channels not addressed by `in_sel` are unaffected by input activity.
- `dat[k]` keeps its last value after a drain; it is not zeroed.
- While `vld[k]=1` and `out_ready[k]=0`, `dat[k]` is held stable.
- While `in_ready=0`, the source must hold `in_data` and `in_sel` steady. Changing `in_sel` while stalled is legal but must not cause any state change in that cycle.
- `out_ready[k]` while `vld[k]=0` has no effect.

## Timing
- Reset values (asynchronous): `out_valid`=4'b0000, `out_data`=0, `cnt`=0. `in_ready` therefore reads 1 immediately after reset.
- Latency: an input accepted at edge N appears on `out_valid`/`out_data` after edge N, i.e. one cycle.
- Throughput: one beat per cycle into any channel whose sink keeps `out_ready` high.
- Reset asserted mid-operation: all held beats are discarded, no output transfer is counted, and `out_valid` drops asynchronously.
- Counter wrap: a counter at 2^CNT_W−1 plus one accepted beat becomes 0. There is no saturation and no overflow flag.

## Configuration
- `STREAM_DEMUX_CNT_EN` defined:
  - Adds `cnt` and `cnt_clr`.
  - Counter k increments by 1 on every input transfer with `in_sel`=k.
  - `cnt_clr` takes priority over an increment in the same cycle; the result is 0.
- Not defined:
  - The `cnt` and `cnt_clr` ports and the counter registers do not exist.
  - All other behaviour is identical.

## Test plan
- Reset release, `in_valid`=0 → `out_valid`=0000, `out_data`=0, `in_ready`=1.
- With `out_ready`=1111, drive `in_data`=4'hA/`in_sel`=0, then 4'h5/sel 1, then 4'h3/sel 2, then 4'hC/sel 3 on consecutive cycles → each channel pulses valid for exactly one cycle, one cycle after acceptance, with the matching data.
- Hold `out_ready[2]`=0. Send 4'h7 to sel 2, then 4'h9 to sel 2 → the second beat sees `in_ready`=0 and channel c holds 4'h7. Raise `out_ready[2]` → 4'h7 drains and 4'h9 is accepted in that same cycle, then appears next cycle.
- Channel c stalled while sending 4'h1 to sel 0 and 4'h4 to sel 3 → both are accepted immediately (channel c does not block a or d).
- Assert `rst_n`=0 for one cycle while 2 beats are held → `out_valid`=0000 asynchronously; with counters enabled, `cnt`=0.
- `STREAM_DEMUX_CNT_EN`, `CNT_W`=2: send 5 beats to channel b → `cnt` b = 1 (wrapped). Assert `cnt_clr` in the same cycle as a sixth beat → 0.
